// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - raster coordinate and sync bundle from vga_sync_gen to the shape generators
interface vga_sync_gen_if;
  logic [9:0] HCount;
  logic [9:0] VCount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       pixel_tick;
  logic       frame_start;

  modport master (
    output HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start
  );

  modport slave (
    input HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - raster timing generator: pixel divider, H/V counters, sync/blank decode
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vid
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  if (H_TOTAL > 1024) begin : g_h_total_check
    $error("vga_sync_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_check
    $error("vga_sync_gen: V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
    $error("vga_sync_gen: CLK_DIV outside 1..16");
  end

  logic [3:0] div_cnt;
  logic [3:0] div_next;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       in_hsync;
  logic       in_vsync;
  logic       visible;
  logic       frame_wrap;

  always_comb begin
    div_next = (div_cnt == DIV_MAX) ? 4'd0 : div_cnt + 4'd1;
  end

  // The coordinate only moves on edges where the registered tick is already high.
  always_comb begin
    h_next = vid.HCount;
    v_next = vid.VCount;
    if (vid.pixel_tick) begin
      if (vid.HCount == H_MAX) begin
        h_next = 10'd0;
        v_next = (vid.VCount == V_MAX) ? 10'd0 : vid.VCount + 10'd1;
      end else begin
        h_next = vid.HCount + 10'd1;
      end
    end
  end

  // Decode from the next-state coordinate so sync/blank switch on the same edge as the counters.
  always_comb begin
    in_hsync   = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
    in_vsync   = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
    visible    = (h_next < H_VIS) && (v_next < V_VIS);
    frame_wrap = vid.pixel_tick && (vid.HCount == H_MAX) && (vid.VCount == V_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt         <= 4'd0;
      vid.HCount      <= 10'd0;
      vid.VCount      <= 10'd0;
      vid.hsync       <= 1'b1;
      vid.vsync       <= 1'b1;
      vid.video_on    <= 1'b1;
      vid.pixel_tick  <= 1'b0;
      vid.frame_start <= 1'b0;
    end else begin
      div_cnt         <= div_next;
      vid.pixel_tick  <= (div_next == DIV_MAX);
      vid.HCount      <= h_next;
      vid.VCount      <= v_next;
      vid.hsync       <= !in_hsync;
      vid.vsync       <= !in_vsync;
      vid.video_on    <= visible;
      vid.frame_start <= frame_wrap;
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - bench for vga_sync_gen: default, CLK_DIV=1 and a shrunken raster
module tb_vga_sync_gen;
  localparam int CD [3] = '{2, 1, 3};
  localparam int HD [3] = '{640, 640, 8};
  localparam int HF [3] = '{16, 16, 2};
  localparam int HS [3] = '{96, 96, 3};
  localparam int HB [3] = '{48, 48, 2};
  localparam int VD [3] = '{480, 480, 5};
  localparam int VF [3] = '{10, 10, 2};
  localparam int VS [3] = '{2, 2, 2};
  localparam int VB [3] = '{33, 33, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   e = 0;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if vif0();
  vga_sync_gen_if vif1();
  vga_sync_gen_if vif2();

  vga_sync_gen #(.CLK_DIV(CD[0]), .H_DISPLAY(HD[0]), .H_FRONT(HF[0]), .H_SYNC(HS[0]), .H_BACK(HB[0]),
                 .V_DISPLAY(VD[0]), .V_FRONT(VF[0]), .V_SYNC(VS[0]), .V_BACK(VB[0]))
    dut0 (.clk(clk), .rst_n(rst_n), .vid(vif0.master));
  vga_sync_gen #(.CLK_DIV(CD[1]), .H_DISPLAY(HD[1]), .H_FRONT(HF[1]), .H_SYNC(HS[1]), .H_BACK(HB[1]),
                 .V_DISPLAY(VD[1]), .V_FRONT(VF[1]), .V_SYNC(VS[1]), .V_BACK(VB[1]))
    dut1 (.clk(clk), .rst_n(rst_n), .vid(vif1.master));
  vga_sync_gen #(.CLK_DIV(CD[2]), .H_DISPLAY(HD[2]), .H_FRONT(HF[2]), .H_SYNC(HS[2]), .H_BACK(HB[2]),
                 .V_DISPLAY(VD[2]), .V_FRONT(VF[2]), .V_SYNC(VS[2]), .V_BACK(VB[2]))
    dut2 (.clk(clk), .rst_n(rst_n), .vid(vif2.master));

  // Packed view: {HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start}
  logic [24:0] obs [3];
  assign obs[0] = {vif0.HCount, vif0.VCount, vif0.hsync, vif0.vsync, vif0.video_on, vif0.pixel_tick, vif0.frame_start};
  assign obs[1] = {vif1.HCount, vif1.VCount, vif1.hsync, vif1.vsync, vif1.video_on, vif1.pixel_tick, vif1.frame_start};
  assign obs[2] = {vif2.HCount, vif2.VCount, vif2.hsync, vif2.vsync, vif2.video_on, vif2.pixel_tick, vif2.frame_start};

  // Edges seen since the last reset edge; 0 means the reset values are showing.
  always @(posedge clk) begin
    if (!rst_n) e <= 0;
    else        e <= e + 1;
  end

  function automatic logic [24:0] pk(input int h, input int v, input bit hs, input bit vs,
                                     input bit vo, input bit t, input bit f);
    return {10'(h), 10'(v), hs, vs, vo, t, f};
  endfunction

  // A tick is high after edge n when n is the last clock of a divider period; the
  // raster moves one pixel on the edge following each tick.
  function automatic logic [24:0] model(input int i, input int n);
    int d, ht, vt, p, h, v;
    bit tick, adv, hsn, vsn, vo, fs;
    d    = CD[i];
    ht   = HD[i] + HF[i] + HS[i] + HB[i];
    vt   = VD[i] + VF[i] + VS[i] + VB[i];
    tick = (n >= 1) && (n % d == d - 1);
    adv  = (n >= 2) && ((n - 1) % d == d - 1);
    if (d == 1) p = (n >= 1) ? n - 1 : 0;
    else        p = n / d;
    h    = p % ht;
    v    = (p / ht) % vt;
    hsn  = !((h >= HD[i] + HF[i]) && (h < HD[i] + HF[i] + HS[i]));
    vsn  = !((v >= VD[i] + VF[i]) && (v < VD[i] + VF[i] + VS[i]));
    vo   = (h < HD[i]) && (v < VD[i]);
    fs   = adv && (p % (ht * vt) == 0);
    return pk(h, v, hsn, vsn, vo, tick, fs);
  endfunction

  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (e=%0d)", name, act, exp, e);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) chk($sformatf("model_dut%0d", i), obs[i], model(i, e));
    end
  end

  typedef struct {
    int          inst;
    int          at;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl [$];
  int   n_rst;
  int   n_run;
  bit   found;

  initial begin
    tbl.push_back('{0, 0,    pk(0, 0, 1, 1, 1, 0, 0)});
    tbl.push_back('{1, 0,    pk(0, 0, 1, 1, 1, 0, 0)});
    tbl.push_back('{2, 0,    pk(0, 0, 1, 1, 1, 0, 0)});
    tbl.push_back('{0, 1,    pk(0, 0, 1, 1, 1, 1, 0)});
    tbl.push_back('{1, 1,    pk(0, 0, 1, 1, 1, 1, 0)});
    tbl.push_back('{0, 2,    pk(1, 0, 1, 1, 1, 0, 0)});
    tbl.push_back('{1, 2,    pk(1, 0, 1, 1, 1, 1, 0)});
    tbl.push_back('{2, 23,   pk(7, 0, 1, 1, 1, 1, 0)});
    tbl.push_back('{2, 24,   pk(8, 0, 1, 1, 0, 0, 0)});
    tbl.push_back('{2, 30,   pk(10, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{2, 224,  pk(14, 4, 1, 1, 0, 1, 0)});
    tbl.push_back('{2, 225,  pk(0, 5, 1, 1, 0, 0, 0)});
    tbl.push_back('{2, 314,  pk(14, 6, 1, 1, 0, 1, 0)});
    tbl.push_back('{2, 315,  pk(0, 7, 1, 0, 0, 0, 0)});
    tbl.push_back('{2, 345,  pk(10, 7, 0, 0, 0, 0, 0)});
    tbl.push_back('{2, 360,  pk(0, 8, 1, 0, 0, 0, 0)});
    tbl.push_back('{2, 405,  pk(0, 9, 1, 1, 0, 0, 0)});
    tbl.push_back('{2, 449,  pk(14, 9, 1, 1, 0, 1, 0)});
    tbl.push_back('{2, 450,  pk(0, 0, 1, 1, 1, 0, 1)});
    tbl.push_back('{2, 451,  pk(0, 0, 1, 1, 1, 0, 0)});
    tbl.push_back('{1, 800,  pk(799, 0, 1, 1, 0, 1, 0)});
    tbl.push_back('{1, 801,  pk(0, 1, 1, 1, 1, 1, 0)});
    tbl.push_back('{0, 1278, pk(639, 0, 1, 1, 1, 0, 0)});
    tbl.push_back('{0, 1280, pk(640, 0, 1, 1, 0, 0, 0)});
    tbl.push_back('{0, 1311, pk(655, 0, 1, 1, 0, 1, 0)});
    tbl.push_back('{0, 1312, pk(656, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{0, 1502, pk(751, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{0, 1504, pk(752, 0, 1, 1, 0, 0, 0)});
    tbl.push_back('{0, 1599, pk(799, 0, 1, 1, 0, 1, 0)});
    tbl.push_back('{0, 1600, pk(0, 1, 1, 1, 1, 0, 0)});

    // Reset held for 3 clocks, released on a falling edge.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    foreach (tbl[k]) begin
      for (int w = 0; w < 5000 && e < tbl[k].at; w++) @(negedge clk);
      chk($sformatf("reach_e%0d", tbl[k].at), 25'(e), 25'(tbl[k].at));
      chk($sformatf("vec_dut%0d_e%0d", tbl[k].inst, tbl[k].at), obs[tbl[k].inst], tbl[k].exp);
    end

    // Reset mid-line while the divider is part-way through a pixel.
    found = 1'b0;
    for (int w = 0; w < 4000 && !found; w++) begin
      @(negedge clk);
      if (obs[0][24:15] == 10'd300 && obs[0][1] == 1'b0) found = 1'b1;
    end
    chk("midop_reach", 25'(found), 25'd1);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("midop_rst_dut%0d", i), obs[i], pk(0, 0, 1, 1, 1, 0, 0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("midop_first_tick", obs[0], pk(0, 0, 1, 1, 1, 1, 0));
    @(negedge clk);
    chk("midop_first_step", obs[0], pk(1, 0, 1, 1, 1, 0, 0));

    repeat (6000) @(negedge clk);

    // Randomly timed resets of random length; the running model checks everything.
    for (int r = 0; r < 8; r++) begin
      n_run = int'($urandom_range(50, 3000));
      n_rst = int'($urandom_range(1, 4));
      repeat (n_run) @(negedge clk);
      rst_n = 1'b0;
      repeat (n_rst) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (2000) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator directly upstream of the object/shape generators.
- Divides the system clock down to a pixel rate.
- Produces the HCount/VCount pixel coordinates that object_square-style blocks decode, together with the hsync/vsync monitor strobes, a video_on blanking flag and a frame_start pulse.
- Default timing is 640x480 @ 60 Hz, with a 100 MHz clock and CLK_DIV=4, or a 50 MHz clock and CLK_DIV=2.

Parameters:
CLK_DIV, 2, system clocks per pixel (1..16)
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
HCount  output  10  current pixel column, 0..H_TOTAL-1
VCount  output  10  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
video_on  output  1  high when HCount<H_DISPLAY and VCount<V_DISPLAY
pixel_tick  output  1  one-clk strobe; the coordinate advances on the next edge
frame_start  output  1  one-clk pulse in the clock where the coordinate becomes (0,0)

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525). Both must be ≤1024; an elaboration-time check flags a violation.
- Reset: sampled only on a rising clk edge with rst_n=0, and overrides everything, mid-line or mid-frame included. Reset values:
  - div counter=0, HCount=0, VCount=0
  - hsync=1, vsync=1, video_on=1
  - pixel_tick=0, frame_start=0
- Divider: counter runs 0..CLK_DIV-1 and wraps. pixel_tick is registered and high for exactly one clk each time the divider reaches CLK_DIV-1. With CLK_DIV=1, pixel_tick is constant 1 after the first clk following reset release.
- Counter advance: on a clk edge where pixel_tick=1:
  - HCount increments.
  - At HCount=H_TOTAL-1, HCount wraps to 0 and VCount increments.
  - At VCount=V_TOTAL-1 on the same HCount wrap, VCount wraps to 0.
  - HCount and VCount never exceed their maxima.
  - No change when pixel_tick=0.
- Decode: hsync, vsync and video_on are registers computed from the next-state counter values, so they change on the same edge as HCount/VCount. No decode lags the coordinate.
  - hsync=0 iff H_DISPLAY+H_FRONT ≤ HCount ≤ H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync=0 iff V_DISPLAY+V_FRONT ≤ VCount ≤ V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
  - video_on=0 for HCount ≥ 640 or VCount ≥ 480.
- frame_start: registered and asserted together with the (H_TOTAL-1,V_TOTAL-1)→(0,0) transition, for one clk. It is not asserted on the reset release itself.
- Widths: all comparisons are done as 10-bit unsigned. Parameter sums are computed at elaboration.
- FSM: none beyond the divider/line/frame counters. Coordinate hold time is exactly CLK_DIV clks per pixel.

Test Plan:
- Reset, CLK_DIV=2: hold rst_n=0 for 3 clks, then release. Outputs read HCount=0, VCount=0, hsync=1, vsync=1, video_on=1, frame_start=0. pixel_tick pulses every 2nd clk and HCount reads 1 after the first tick.
- Line timing: run one full line. hsync falls on the edge where HCount becomes 656 and rises when it becomes 752. video_on falls when HCount becomes 640. HCount 799→0 coincides with VCount 0→1.
- Frame timing: run to (799,524). The next tick gives (0,0), frame_start=1 for one clk and video_on=1. vsync is low exactly while VCount is 490..491 (1600 pixels). The frame lasts 420000 pixels = 840000 clks.
- Blanking: at VCount=480..524, video_on=0 for every HCount, while hsync keeps pulsing each line.
- Reset mid-operation: assert rst_n=0 at (300,200) in the middle of a divider count. The next edge gives all reset values, and the counting restart matches the reset scenario.
- CLK_DIV=1 build: HCount increments every clk after reset release, and one line takes 800 clks.
